// File: rtl/muxn_pkg.sv
// Shared types and sizing helpers for the synchronous N-way mux with blanking.
// Imported by muxn_sync and gap_counter.
package muxn_pkg;

  typedef logic [0:0] state_t;

  localparam state_t RUN   = 1'b0;
  localparam state_t BLANK = 1'b1;

  // Width of a channel index; a 1-bit floor keeps degenerate sizes legal.
  function automatic int sel_width(input int n_in);
    return (n_in < 2) ? 1 : $clog2(n_in);
  endfunction

  function automatic int cnt_width(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter that times the blanking interval of a channel switch.
// Counts down to zero and then holds; done flags the final blank cycle.
module gap_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/muxn_sync.sv
// Registered N-way channel mux that blanks its output for GAP cycles whenever
// the selected channel changes, with a ready/valid select handshake.
module muxn_sync
  import muxn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int GAP   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN*WIDTH-1:0]        d,
  input  logic [sel_width(N_IN)-1:0]   sel_req,
  input  logic                         sel_valid,
  output logic                         sel_ready,
  output logic [WIDTH-1:0]             z,
  output logic                         z_valid,
  output logic [sel_width(N_IN)-1:0]   cur_sel,
  output logic                         sel_err
);

  localparam int SW = sel_width(N_IN);
  localparam int CW = cnt_width(GAP);
  localparam logic [SW:0]   N_IN_V = (SW + 1)'(N_IN);
  localparam logic [CW-1:0] GAP_V  = CW'(GAP);

  if (N_IN < 2 || WIDTH < 1) begin : g_param_check
    $error("muxn_sync: N_IN must be >= 2 and WIDTH must be >= 1");
  end

  state_t           state_q, state_d;
  logic [SW-1:0]    cur_sel_q, cur_sel_d;
  logic [SW-1:0]    pending_q, pending_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             z_valid_q, z_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             cnt_load;
  logic             cnt_done;
  logic             accept;
  logic             out_of_range;
  logic [WIDTH-1:0] sel_data;

  assign sel_ready    = (state_q == RUN);
  assign accept       = sel_valid && sel_ready;
  assign out_of_range = ({1'b0, sel_req} >= N_IN_V);

  // A zero GAP switches in place on the accept edge and never visits BLANK.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pending_d = pending_q;
    sel_err_d = 1'b0;
    cnt_load  = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (out_of_range) begin
            sel_err_d = 1'b1;
          end else if (sel_req != cur_sel_q) begin
            if (GAP == 0) begin
              cur_sel_d = sel_req;
            end else begin
              pending_d = sel_req;
              cnt_load  = 1'b1;
              state_d   = BLANK;
            end
          end
        end
      end
      BLANK: begin
        if (cnt_done) begin
          cur_sel_d = pending_q;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output is keyed off the next channel so the first live word after a switch
  // is the new channel sampled on the RUN-entry edge.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (cur_sel_d == SW'(i)) begin
        sel_data = d[i*WIDTH +: WIDTH];
      end
    end
    z_d       = (state_d == RUN) ? sel_data : '0;
    z_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cur_sel_q <= '0;
      pending_q <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pending_q <= pending_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  gap_counter #(
    .CW(CW)
  ) u_gap_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (GAP_V),
    .done     (cnt_done)
  );

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign cur_sel = cur_sel_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_muxn_sync.sv
// Self-checking bench for muxn_sync: three instances (GAP=2/N_IN=4, GAP=2/N_IN=3,
// GAP=0/N_IN=4) driven from a vector table with a queue of expected outputs.
module tb_muxn_sync;

  typedef struct {
    int          dut_id;
    logic [31:0] d;
    logic [1:0]  sel_req;
    logic        sel_valid;
    logic [7:0]  z;
    logic        zv;
    logic [1:0]  cur;
    logic        rdy;
    logic        err;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] d_a = 32'h44332211;
  logic [1:0]  sel_a = '0;
  logic        val_a = 1'b0;
  logic        rdy_a, zv_a, err_a;
  logic [7:0]  z_a;
  logic [1:0]  cur_a;

  logic [23:0] d_b = 24'h332211;
  logic [1:0]  sel_b = '0;
  logic        val_b = 1'b0;
  logic        rdy_b, zv_b, err_b;
  logic [7:0]  z_b;
  logic [1:0]  cur_b;

  logic [31:0] d_c = 32'h44332211;
  logic [1:0]  sel_c = '0;
  logic        val_c = 1'b0;
  logic        rdy_c, zv_c, err_c;
  logic [7:0]  z_c;
  logic [1:0]  cur_c;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  muxn_sync #(.WIDTH(8), .N_IN(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .sel_req(sel_a), .sel_valid(val_a),
    .sel_ready(rdy_a), .z(z_a), .z_valid(zv_a), .cur_sel(cur_a), .sel_err(err_a)
  );

  muxn_sync #(.WIDTH(8), .N_IN(3), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .sel_req(sel_b), .sel_valid(val_b),
    .sel_ready(rdy_b), .z(z_b), .z_valid(zv_b), .cur_sel(cur_b), .sel_err(err_b)
  );

  muxn_sync #(.WIDTH(8), .N_IN(4), .GAP(0)) dut_c (
    .clk(clk), .rst(rst), .d(d_c), .sel_req(sel_c), .sel_valid(val_c),
    .sel_ready(rdy_c), .z(z_c), .z_valid(zv_c), .cur_sel(cur_c), .sel_err(err_c)
  );

  function automatic vec_t mk(input int id, input logic [31:0] dv, input logic [1:0] sr,
                              input logic sv, input logic [7:0] ez, input logic ezv,
                              input logic [1:0] ecur, input logic erdy, input logic eerr,
                              input string nm);
    vec_t v;
    v.dut_id = id; v.d = dv; v.sel_req = sr; v.sel_valid = sv;
    v.z = ez; v.zv = ezv; v.cur = ecur; v.rdy = erdy; v.err = eerr; v.name = nm;
    return v;
  endfunction

  // Compare the addressed instance's outputs against a record's expected fields.
  task automatic checkOutput(input vec_t v);
    logic [7:0] az;
    logic       azv, ardy, aerr;
    logic [1:0] acur;
    case (v.dut_id)
      0:       begin az = z_a; azv = zv_a; acur = cur_a; ardy = rdy_a; aerr = err_a; end
      1:       begin az = z_b; azv = zv_b; acur = cur_b; ardy = rdy_b; aerr = err_b; end
      default: begin az = z_c; azv = zv_c; acur = cur_c; ardy = rdy_c; aerr = err_c; end
    endcase
    n_tests++;
    if ({az, azv, acur, ardy, aerr} !== {v.z, v.zv, v.cur, v.rdy, v.err}) begin
      n_fail++;
      $display("[TB] FAIL %s: got z=%h zv=%b cur=%0d rdy=%b err=%b, want z=%h zv=%b cur=%0d rdy=%b err=%b",
               v.name, az, azv, acur, ardy, aerr, v.z, v.zv, v.cur, v.rdy, v.err);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    case (v.dut_id)
      0:       begin d_a = v.d;        sel_a = v.sel_req; val_a = v.sel_valid; end
      1:       begin d_b = v.d[23:0];  sel_b = v.sel_req; val_b = v.sel_valid; end
      default: begin d_c = v.d;        sel_c = v.sel_req; val_c = v.sel_valid; end
    endcase
    sb.push_back(v);
  endtask

  task automatic stepAndCheck(input vec_t v);
    vec_t e;
    applyStimulus(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      checkOutput(e);
    end
  endtask

  initial begin
    // Main instance: GAP=2, four channels {44,33,22,11}.
    vecs.push_back(mk(0, 32'h44332211, 2'd0, 1'b0, 8'hA5, 1, 0, 1, 0, "a_latency_setup"));
    vecs[0].d = 32'h443322A5;
    vecs.push_back(mk(0, 32'h44332211, 2'd0, 1'b1, 8'h11, 1, 0, 1, 0, "a_same_channel"));
    vecs.push_back(mk(0, 32'h44332211, 2'd2, 1'b1, 8'h00, 0, 0, 0, 0, "a_switch_blank1"));
    vecs.push_back(mk(0, 32'h44332211, 2'd1, 1'b1, 8'h00, 0, 0, 0, 0, "a_blank2_ignore_req"));
    vecs.push_back(mk(0, 32'h44332211, 2'd0, 1'b0, 8'h33, 1, 2, 1, 0, "a_switch_live"));
    vecs.push_back(mk(0, 32'h44662211, 2'd0, 1'b0, 8'h66, 1, 2, 1, 0, "a_track_ch2"));
    vecs.push_back(mk(0, 32'h44662211, 2'd2, 1'b1, 8'h66, 1, 2, 1, 0, "a_same_ch2"));
    vecs.push_back(mk(0, 32'h44662211, 2'd3, 1'b1, 8'h00, 0, 2, 0, 0, "a_sw3_blank1"));
    vecs.push_back(mk(0, 32'h44662211, 2'd0, 1'b0, 8'h00, 0, 2, 0, 0, "a_sw3_blank2"));
    vecs.push_back(mk(0, 32'h44662211, 2'd0, 1'b0, 8'h44, 1, 3, 1, 0, "a_sw3_live"));
    // Three-channel instance: index 3 is out of range.
    vecs.push_back(mk(1, 32'h00332211, 2'd3, 1'b1, 8'h11, 1, 0, 1, 1, "b_oor_err"));
    vecs.push_back(mk(1, 32'h00332211, 2'd0, 1'b0, 8'h11, 1, 0, 1, 0, "b_oor_err_clear"));
    vecs.push_back(mk(1, 32'h00332211, 2'd2, 1'b1, 8'h00, 0, 0, 0, 0, "b_switch_blank1"));
    vecs.push_back(mk(1, 32'h00332211, 2'd0, 1'b0, 8'h00, 0, 0, 0, 0, "b_switch_blank2"));
    vecs.push_back(mk(1, 32'h00332211, 2'd0, 1'b0, 8'h33, 1, 2, 1, 0, "b_switch_live"));
    // GAP=0 instance: switches in place with no blank cycle.
    vecs.push_back(mk(2, 32'h44332211, 2'd0, 1'b0, 8'h11, 1, 0, 1, 0, "c_idle"));
    vecs.push_back(mk(2, 32'h44332211, 2'd1, 1'b1, 8'h22, 1, 1, 1, 0, "c_switch1"));
    vecs.push_back(mk(2, 32'h44332211, 2'd0, 1'b0, 8'h22, 1, 1, 1, 0, "c_hold1"));
    vecs.push_back(mk(2, 32'h44332211, 2'd3, 1'b1, 8'h44, 1, 3, 1, 0, "c_switch3"));

    repeat (3) @(posedge clk);
    #1;
    checkOutput(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, "a_in_reset"));
    checkOutput(mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 0, "b_in_reset"));

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(mk(0, 0, 0, 0, 8'h11, 1, 0, 1, 0, "a_first_after_reset"));

    foreach (vecs[i]) stepAndCheck(vecs[i]);

    // Abort: enter BLANK toward channel 1, then reset asynchronously mid-gap.
    stepAndCheck(mk(0, 32'h44332211, 2'd1, 1'b1, 8'h00, 0, 3, 0, 0, "a_abort_enter_blank"));
    #2;
    rst = 1'b1;
    #1;
    checkOutput(mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, "a_abort_async_clear"));
    @(negedge clk);
    rst   = 1'b0;
    val_a = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(mk(0, 0, 0, 0, 8'h11, 1, 0, 1, 0, "a_abort_release"));
    repeat (3) @(posedge clk);
    #1;
    checkOutput(mk(0, 0, 0, 0, 8'h11, 1, 0, 1, 0, "a_abort_no_pending"));

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
